// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: puts stage-M loads/stores onto the data-memory handshake
// bus, stalls the pipeline while memory is busy, and hands stage W the raw
// read word plus the side information it needs to format it.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a new access from stage M
// ISSUE    | memory request presented, waiting for mem_req_ready
// WAIT_RSP | load issued, waiting for mem_rsp_valid or the timeout
// DONE     | one-cycle completion (rsp_valid), pipeline released
module mem_access_ctrl #(
  parameter logic [31:0] HW_BASE = 32'hFFFF_FF00,
  parameter logic [31:0] HW_MASK = 32'hFFFF_FF00,
  parameter int          TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_alucode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [5:0]  alucode,
  output logic [4:0]  byte_offset,
  output logic        is_hardware,
  output logic        misaligned,
  output logic        bus_err
);

  // Load/store codes shared with the ALU decoder of the pipeline.
  localparam logic [5:0] ALU_LB  = 6'd22;
  localparam logic [5:0] ALU_LH  = 6'd23;
  localparam logic [5:0] ALU_LW  = 6'd24;
  localparam logic [5:0] ALU_LBU = 6'd25;
  localparam logic [5:0] ALU_LHU = 6'd26;
  localparam logic [5:0] ALU_SB  = 6'd27;
  localparam logic [5:0] ALU_SH  = 6'd28;
  localparam logic [5:0] ALU_SW  = 6'd29;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_t;

  state_t state, state_nxt;

  logic          is_load, is_store, is_half, is_word, is_mem;
  logic          addr_mis, hw_hit;
  logic [3:0]    wstrb_nxt;
  logic [31:0]   wdata_nxt;
  logic          accept, cap_rsp, timeout_hit;
  logic [CW-1:0] wait_cnt;
  logic          mis_q, err_q;

  // Classify the incoming code and check alignment / hardware region.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (req_alucode)
      ALU_LB, ALU_LBU: is_load = 1'b1;
      ALU_LH, ALU_LHU: begin is_load = 1'b1; is_half = 1'b1; end
      ALU_LW:          begin is_load = 1'b1; is_word = 1'b1; end
      ALU_SB:          is_store = 1'b1;
      ALU_SH:          begin is_store = 1'b1; is_half = 1'b1; end
      ALU_SW:          begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
    is_mem   = is_load | is_store;
    addr_mis = (is_half & req_addr[0]) | (is_word & (req_addr[1:0] != 2'b00));
    hw_hit   = ((req_addr & HW_MASK) == HW_BASE);
  end

  // Store lane encoding; loads carry no byte enables.
  always_comb begin
    wstrb_nxt = 4'b0000;
    wdata_nxt = 32'h0;
    if (is_store) begin
      if (is_word) begin
        wstrb_nxt = 4'b1111;
        wdata_nxt = req_wdata;
      end else if (is_half) begin
        wstrb_nxt = 4'b0011 << req_addr[1:0];
        wdata_nxt = {2{req_wdata[15:0]}};
      end else begin
        wstrb_nxt = 4'b0001 << req_addr[1:0];
        wdata_nxt = {4{req_wdata[7:0]}};
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    cap_rsp     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && is_mem) begin
          accept    = 1'b1;
          state_nxt = (addr_mis || hw_hit) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          if (mem_we) begin
            state_nxt = DONE;
          end else if (mem_rsp_valid) begin
            cap_rsp   = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          cap_rsp   = 1'b1;
          state_nxt = DONE;
        end else if (wait_cnt == CW'(TIMEOUT)) begin
          timeout_hit = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Wait counter: 0 on the first WAIT_RSP cycle, so the timeout lands
  // TIMEOUT+1 cycles after entering WAIT_RSP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    wait_cnt <= '0;
    else if (state == WAIT_RSP) wait_cnt <= wait_cnt + 1'b1;
    else                        wait_cnt <= '0;
  end

  // Access payload and side information, held until the next acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alucode     <= '0;
      byte_offset <= '0;
      is_hardware <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wstrb   <= '0;
      mem_wdata   <= '0;
      rsp_data    <= '0;
      mis_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        alucode     <= req_alucode;
        byte_offset <= {req_addr[1:0], 3'b000};
        is_hardware <= hw_hit;
        mem_we      <= is_store;
        mem_addr    <= {req_addr[31:2], 2'b00};
        mem_wstrb   <= wstrb_nxt;
        mem_wdata   <= wdata_nxt;
        rsp_data    <= '0;
        mis_q       <= addr_mis;
        err_q       <= 1'b0;
      end
      if (cap_rsp) rsp_data <= mem_rdata;
      if (timeout_hit) begin
        rsp_data <= '0;
        err_q    <= 1'b1;
      end
    end
  end

  assign req_ready     = (state == IDLE);
  assign mem_req_valid = (state == ISSUE);
  assign rsp_valid     = (state == DONE);
  assign misaligned    = (state == DONE) & mis_q;
  assign bus_err       = (state == DONE) & err_q;
  assign stall         = ((state == IDLE) & req_valid & is_mem)
                       | (state == ISSUE) | (state == WAIT_RSP);

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam logic [5:0] ALU_LB  = 6'd22;
  localparam logic [5:0] ALU_LH  = 6'd23;
  localparam logic [5:0] ALU_LW  = 6'd24;
  localparam logic [5:0] ALU_SB  = 6'd27;
  localparam logic [5:0] ALU_SH  = 6'd28;
  localparam logic [5:0] ALU_SW  = 6'd29;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_alucode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [5:0]  alucode;
  logic [4:0]  byte_offset;
  logic        is_hardware;
  logic        misaligned;
  logic        bus_err;

  int total = 0;
  int bad = 0;

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_alucode(req_alucode),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .alucode(alucode), .byte_offset(byte_offset), .is_hardware(is_hardware),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid     = 1'b0;
    req_alucode   = 6'd0;
    req_addr      = 32'h0;
    req_wdata     = 32'h0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = 32'h0;
  endtask

  task automatic issue(input logic [5:0] code, input logic [31:0] addr, input logic [31:0] wd);
    req_valid   = 1'b1;
    req_alucode = code;
    req_addr    = addr;
    req_wdata   = wd;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #12;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    total++; if ({rsp_valid, mem_req_valid, misaligned, bus_err, is_hardware} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {rsp_valid, mem_req_valid, misaligned, bus_err, is_hardware}); end
    total++; if ({rsp_data, alucode, byte_offset} !== 43'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {rsp_data, alucode, byte_offset}); end
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_lb();
    issue(ALU_LB, 32'h0000_1003, 32'h0);
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lb_stall_c0 got=%b exp=1", stall); end
    next_cycle(); idle_inputs(); mem_req_ready = 1'b1;
    @(negedge clk);
    total++; if ({mem_req_valid, mem_we, stall} !== 3'b101) begin bad++; $display("FAIL lb_issue got=%b exp=101", {mem_req_valid, mem_we, stall}); end
    total++; if (mem_addr !== 32'h0000_1000 || mem_wstrb !== 4'b0000) begin bad++; $display("FAIL lb_payload got=%h/%b exp=00001000/0000", mem_addr, mem_wstrb); end
    next_cycle(); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h80FF_0000;
    @(negedge clk);
    total++; if ({stall, rsp_valid, mem_req_valid} !== 3'b100) begin bad++; $display("FAIL lb_wait got=%b exp=100", {stall, rsp_valid, mem_req_valid}); end
    next_cycle(); mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    total++; if ({rsp_valid, stall} !== 2'b10) begin bad++; $display("FAIL lb_done got=%b exp=10", {rsp_valid, stall}); end
    total++; if (rsp_data !== 32'h80FF_0000) begin bad++; $display("FAIL lb_rsp_data got=%h exp=80ff0000", rsp_data); end
    total++; if (byte_offset !== 5'd24 || alucode !== ALU_LB) begin bad++; $display("FAIL lb_side got=%0d/%0d exp=24/%0d", byte_offset, alucode, ALU_LB); end
    next_cycle();
    @(negedge clk);
    total++; if ({rsp_valid, req_ready} !== 2'b01 || rsp_data !== 32'h80FF_0000) begin bad++; $display("FAIL lb_hold got=%b/%h exp=01/80ff0000", {rsp_valid, req_ready}, rsp_data); end
    next_cycle();
  endtask

  task automatic test_hardware();
    issue(ALU_LW, 32'hFFFF_FF04, 32'h0);
    next_cycle(); idle_inputs();
    @(negedge clk);
    total++; if ({rsp_valid, mem_req_valid, is_hardware} !== 3'b101) begin bad++; $display("FAIL hw_done got=%b exp=101", {rsp_valid, mem_req_valid, is_hardware}); end
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL hw_rsp_data got=%h exp=0", rsp_data); end
    next_cycle();
  endtask

  task automatic test_sh_stall();
    issue(ALU_SH, 32'h0000_2002, 32'h0000_ABCD);
    next_cycle(); idle_inputs();
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) mem_req_ready = 1'b1;
      @(negedge clk);
      total++; if ({mem_req_valid, mem_we, rsp_valid, stall} !== 4'b1101) begin bad++; $display("FAIL sh_issue_c%0d got=%b exp=1101", c, {mem_req_valid, mem_we, rsp_valid, stall}); end
      total++; if (mem_addr !== 32'h2000 || mem_wstrb !== 4'b1100 || mem_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_payload_c%0d got=%h/%b/%h exp=00002000/1100/abcdabcd", c, mem_addr, mem_wstrb, mem_wdata); end
      next_cycle();
    end
    mem_req_ready = 1'b0;
    @(negedge clk);
    total++; if ({rsp_valid, stall, mem_req_valid} !== 3'b100 || rsp_data !== 32'h0) begin bad++; $display("FAIL sh_done got=%b/%h exp=100/0", {rsp_valid, stall, mem_req_valid}, rsp_data); end
    next_cycle();
  endtask

  task automatic test_misaligned();
    issue(ALU_LW, 32'h0000_1002, 32'h0);
    next_cycle(); idle_inputs();
    @(negedge clk);
    total++; if ({misaligned, rsp_valid, mem_req_valid, bus_err} !== 4'b1100) begin bad++; $display("FAIL mis_lw got=%b exp=1100", {misaligned, rsp_valid, mem_req_valid, bus_err}); end
    next_cycle();
    @(negedge clk);
    total++; if ({misaligned, rsp_valid, mem_req_valid} !== 3'b000) begin bad++; $display("FAIL mis_pulse_end got=%b exp=000", {misaligned, rsp_valid, mem_req_valid}); end
    issue(ALU_SB, 32'h0000_1003, 32'h0000_005A);
    next_cycle(); idle_inputs(); mem_req_ready = 1'b1;
    @(negedge clk);
    total++; if ({mem_req_valid, mem_we, misaligned} !== 3'b110) begin bad++; $display("FAIL sb_issue got=%b exp=110", {mem_req_valid, mem_we, misaligned}); end
    total++; if (mem_wstrb !== 4'b1000 || mem_wdata !== 32'h5A5A_5A5A || mem_addr !== 32'h1000) begin bad++; $display("FAIL sb_payload got=%b/%h/%h exp=1000/5a5a5a5a/00001000", mem_wstrb, mem_wdata, mem_addr); end
    next_cycle(); mem_req_ready = 1'b0;
    @(negedge clk);
    total++; if ({rsp_valid, misaligned, byte_offset} !== {2'b10, 5'd24}) begin bad++; $display("FAIL sb_done got=%b/%0d exp=10/24", {rsp_valid, misaligned}, byte_offset); end
    next_cycle();
  endtask

  task automatic test_same_cycle_rsp();
    issue(ALU_LW, 32'h0000_4000, 32'h0);
    next_cycle(); idle_inputs();
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    next_cycle(); idle_inputs();
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234_5678) begin bad++; $display("FAIL same_cycle got=%b/%h exp=1/12345678", rsp_valid, rsp_data); end
    next_cycle();
  endtask

  task automatic test_timeout();
    issue(ALU_LW, 32'h0000_3000, 32'h0);
    next_cycle(); idle_inputs(); mem_req_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
    next_cycle(); mem_req_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if ({stall, rsp_valid, bus_err} !== 3'b100) begin bad++; $display("FAIL to_wait_c%0d got=%b exp=100", c, {stall, rsp_valid, bus_err}); end
      next_cycle();
    end
    mem_rsp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if ({bus_err, rsp_valid, stall} !== 3'b110 || rsp_data !== 32'h0) begin bad++; $display("FAIL to_done got=%b/%h exp=110/0", {bus_err, rsp_valid, stall}, rsp_data); end
    next_cycle();
    @(negedge clk);
    total++; if ({bus_err, rsp_valid, req_ready} !== 3'b001 || rsp_data !== 32'h0) begin bad++; $display("FAIL to_late_rsp got=%b/%h exp=001/0", {bus_err, rsp_valid, req_ready}, rsp_data); end
    next_cycle(); idle_inputs();
    @(negedge clk);
    total++; if ({rsp_valid, mem_req_valid, stall} !== 3'b000) begin bad++; $display("FAIL to_quiet got=%b exp=000", {rsp_valid, mem_req_valid, stall}); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    issue(ALU_LW, 32'h0000_5000, 32'h0);
    next_cycle(); idle_inputs(); mem_req_ready = 1'b1;
    next_cycle(); mem_req_ready = 1'b0;
    next_cycle();
    rst = 1'b1;
    #1;
    total++; if ({stall, req_ready, mem_req_valid, rsp_valid} !== 4'b0100) begin bad++; $display("FAIL rst_mid got=%b exp=0100", {stall, req_ready, mem_req_valid, rsp_valid}); end
    total++; if ({alucode, mem_addr} !== 38'h0) begin bad++; $display("FAIL rst_mid_regs got=%h exp=0", {alucode, mem_addr}); end
    @(negedge clk);
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++; if ({rsp_valid, stall} !== 2'b00) begin bad++; $display("FAIL rst_after_c%0d got=%b exp=00", c, {rsp_valid, stall}); end
      next_cycle();
    end
    issue(ALU_LW, 32'h0000_6000, 32'h0);
    next_cycle(); idle_inputs(); mem_req_ready = 1'b1;
    next_cycle(); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_lw_early got=%b exp=0", rsp_valid); end
    next_cycle(); idle_inputs();
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL rst_lw_done got=%b/%h exp=1/cafef00d", rsp_valid, rsp_data); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    issue(6'd0, 32'h0000_7000, 32'h0);
    @(negedge clk);
    total++; if ({req_ready, stall} !== 2'b10) begin bad++; $display("FAIL nop_c0 got=%b exp=10", {req_ready, stall}); end
    next_cycle();
    @(negedge clk);
    total++; if ({mem_req_valid, rsp_valid, req_ready} !== 3'b001) begin bad++; $display("FAIL nop_c1 got=%b exp=001", {mem_req_valid, rsp_valid, req_ready}); end
    issue(ALU_SW, 32'h0000_7000, 32'h1122_3344);
    next_cycle();
    issue(ALU_LH, 32'h0000_7002, 32'h0); mem_req_ready = 1'b1;
    @(negedge clk);
    total++; if (mem_wstrb !== 4'b1111 || mem_wdata !== 32'h1122_3344 || mem_we !== 1'b1) begin bad++; $display("FAIL b2b_sw got=%b/%h/%b exp=1111/11223344/1", mem_wstrb, mem_wdata, mem_we); end
    next_cycle(); mem_req_ready = 1'b0;
    @(negedge clk);
    total++; if ({rsp_valid, req_ready, stall} !== 3'b100) begin bad++; $display("FAIL b2b_done got=%b exp=100", {rsp_valid, req_ready, stall}); end
    next_cycle();
    @(negedge clk);
    total++; if ({req_ready, stall, rsp_valid} !== 3'b110) begin bad++; $display("FAIL b2b_accept got=%b exp=110", {req_ready, stall, rsp_valid}); end
    next_cycle(); idle_inputs(); mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0099;
    @(negedge clk);
    total++; if ({mem_req_valid, mem_we, mem_wstrb} !== 6'b10_0000 || mem_addr !== 32'h7000 || alucode !== ALU_LH) begin bad++; $display("FAIL b2b_lh_issue got=%b/%h/%0d exp=100000/00007000/%0d", {mem_req_valid, mem_we, mem_wstrb}, mem_addr, alucode, ALU_LH); end
    next_cycle(); idle_inputs();
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h99 || byte_offset !== 5'd16) begin bad++; $display("FAIL b2b_lh_done got=%b/%h/%0d exp=1/00000099/16", rsp_valid, rsp_data, byte_offset); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_lb();
    test_hardware();
    test_sh_stall();
    test_misaligned();
    test_same_cycle_rsp();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
